// File: rtl/tmr_vote_monitor.sv
// Triple-modular-redundancy voter with divergence tracking.
// Degrades TMR -> DMR -> HALT as replicas misbehave; all outputs registered.
module tmr_vote_monitor #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned THRESH = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              clear_faults,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] C,
  input  logic              we_A,
  input  logic              we_B,
  input  logic              we_C,
  input  logic [RD_W-1:0]   rd_A,
  input  logic [RD_W-1:0]   rd_B,
  input  logic [RD_W-1:0]   rd_C,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              write_enable,
  output logic [RD_W-1:0]   rd,
  output logic              fault_A,
  output logic              fault_B,
  output logic              fault_C,
  output logic [2:0]        failed,
  output logic [1:0]        mode,
  output logic              system_fault,
  output logic [CNT_W-1:0]  err_cnt_A,
  output logic [CNT_W-1:0]  err_cnt_B,
  output logic [CNT_W-1:0]  err_cnt_C
);

  localparam int unsigned BW     = DATA_W + 1 + RD_W;
  localparam int unsigned CONS_W = 8;
  localparam logic [CONS_W-1:0] THR     = CONS_W'(THRESH);
  localparam logic [CNT_W-1:0]  ERR_MAX = '1;
  localparam logic [CONS_W-1:0] CON_MAX = '1;
  localparam logic [1:0] M_TMR  = 2'd0;
  localparam logic [1:0] M_DMR  = 2'd1;
  localparam logic [1:0] M_HALT = 2'd2;

  logic [BW-1:0]     bun [3];
  logic              eq_ab, eq_bc, eq_ac, all_diff, dmr_agree;
  logic [2:0]        odd, thr_hit;
  logic [1:0]        lo, hi;
  logic [CONS_W-1:0] consec_q [3], consec_d [3], cons_inc [3];
  logic [CNT_W-1:0]  err_q [3], err_d [3], err_inc [3];
  logic [2:0]        flags_q, flags_d, failed_d;
  logic [1:0]        mode_d;
  logic              out_valid_d, we_d, sf_d;
  logic [DATA_W-1:0] result_d;
  logic [RD_W-1:0]   rd_d;

  assign bun[0] = {A, we_A, rd_A};
  assign bun[1] = {B, we_B, rd_B};
  assign bun[2] = {C, we_C, rd_C};

  assign eq_ab    = (bun[0] == bun[1]);
  assign eq_bc    = (bun[1] == bun[2]);
  assign eq_ac    = (bun[0] == bun[2]);
  assign all_diff = ~(eq_ab | eq_bc | eq_ac);
  // One-hot divergent replica when exactly one disagrees with the other two
  assign odd      = {eq_ab & ~eq_bc, eq_ac & ~eq_ab, eq_bc & ~eq_ab};

  // Surviving pair in DMR: lower and higher lettered non-failed replica
  assign lo        = failed[0] ? 2'd1 : 2'd0;
  assign hi        = failed[2] ? 2'd1 : 2'd2;
  assign dmr_agree = (bun[lo] == bun[hi]);

  always_comb begin : incrementers
    thr_hit = '0;
    for (int i = 0; i < 3; i++) begin
      cons_inc[i] = (consec_q[i] == CON_MAX) ? consec_q[i] : consec_q[i] + CONS_W'(1);
      err_inc[i]  = (err_q[i] == ERR_MAX) ? err_q[i] : err_q[i] + CNT_W'(1);
      thr_hit[i]  = (cons_inc[i] >= THR);
    end
  end

  always_comb begin : next_state
    mode_d = mode;
    case (mode)
      M_TMR: begin
        if (in_valid) begin
          if (all_diff)                mode_d = M_HALT;
          else if (|(odd & thr_hit))   mode_d = M_DMR;
        end
      end
      M_DMR:   if (in_valid && !dmr_agree) mode_d = M_HALT;
      default: mode_d = M_HALT;
    endcase
    if (clear_faults) mode_d = M_TMR;
  end

  always_comb begin : output_logic
    out_valid_d = in_valid;
    result_d    = result;
    we_d        = write_enable;
    rd_d        = rd;
    flags_d     = '0;
    failed_d    = failed;
    sf_d        = system_fault;
    consec_d    = consec_q;
    err_d       = err_q;
    if (in_valid) begin
      if (clear_faults || mode == M_TMR) begin
        if (all_diff) begin
          result_d = A;
          rd_d     = rd_A;
          we_d     = 1'b0;
          flags_d  = 3'b111;
          for (int i = 0; i < 3; i++) err_d[i] = err_inc[i];
        end else begin
          {result_d, we_d, rd_d} = odd[0] ? bun[1] : bun[0];
          flags_d = odd;
          for (int i = 0; i < 3; i++) begin
            if (odd[i]) begin
              consec_d[i] = cons_inc[i];
              err_d[i]    = err_inc[i];
              if (thr_hit[i]) failed_d[i] = 1'b1;
            end else begin
              consec_d[i] = '0;
            end
          end
        end
      end else if (mode == M_DMR) begin
        {result_d, we_d, rd_d} = bun[lo];
        if (!dmr_agree) begin
          we_d        = 1'b0;
          flags_d[lo] = 1'b1;
          flags_d[hi] = 1'b1;
          err_d[lo]   = err_inc[lo];
          err_d[hi]   = err_inc[hi];
        end
      end else begin
        result_d = A;
        rd_d     = rd_A;
        we_d     = 1'b0;
        flags_d  = flags_q;
      end
    end
    if (mode_d == M_HALT) sf_d = 1'b1;
    // Clear wins over any failure or count update from this cycle's vote
    if (clear_faults) begin
      failed_d = '0;
      sf_d     = 1'b0;
      consec_d = '{default: '0};
      err_d    = '{default: '0};
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      mode         <= M_TMR;
      out_valid    <= 1'b0;
      result       <= '0;
      write_enable <= 1'b0;
      rd           <= '0;
      flags_q      <= '0;
      failed       <= '0;
      system_fault <= 1'b0;
      consec_q     <= '{default: '0};
      err_q        <= '{default: '0};
    end else begin
      mode         <= mode_d;
      out_valid    <= out_valid_d;
      result       <= result_d;
      write_enable <= we_d;
      rd           <= rd_d;
      flags_q      <= flags_d;
      failed       <= failed_d;
      system_fault <= sf_d;
      consec_q     <= consec_d;
      err_q        <= err_d;
    end
  end

  assign fault_A   = flags_q[0];
  assign fault_B   = flags_q[1];
  assign fault_C   = flags_q[2];
  assign err_cnt_A = err_q[0];
  assign err_cnt_B = err_q[1];
  assign err_cnt_C = err_q[2];

endmodule

// File: doc/tmr_vote_monitor.md
TMR_VOTE_MONITOR -- requirements
Module: tmr_vote_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of each replica result.
REQ-002 SHALL have parameter RD_W, default 5, width of each replica destination register index.
REQ-003 SHALL have parameter THRESH, default 4, consecutive divergences (range 1..255) before a replica is declared failed.
REQ-004 SHALL have parameter CNT_W, default 8, width of the per-replica total-error counters.
REQ-005 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset (one clock domain; synchronous, active-high).
REQ-006 SHALL have ports: in_valid in 1, the replica bundles are valid this cycle; clear_faults in 1, return to TMR and clear fault state.
REQ-007 SHALL have ports: A, B, C in DATA_W each; we_A, we_B, we_C in 1 each; rd_A, rd_B, rd_C in RD_W each, the replica bundles.
REQ-008 SHALL have ports: out_valid out 1; result out DATA_W; write_enable out 1; rd out RD_W, the voted output.
REQ-009 SHALL have ports: fault_A, fault_B, fault_C out 1, per-vote divergence flags; failed out 3, sticky excluded-replica mask, bit0=A, bit1=B, bit2=C.
REQ-010 SHALL have ports: mode out 2, 0=TMR, 1=DMR, 2=HALT; system_fault out 1; err_cnt_A, err_cnt_B, err_cnt_C out CNT_W each.

Function
REQ-011 SHALL compare whole bundles {data, we, rd}; two replicas agree only if all three fields are equal.
REQ-012 SHALL register all outputs, with 1-cycle latency: the bundle sampled at edge N appears after edge N.
REQ-013 SHALL drive out_valid as in_valid delayed one cycle; when in_valid=0, vote outputs, fault flags and counters SHALL hold, except that fault_A..C SHALL clear to 0.
REQ-014 TMR, all agree: SHALL output the A bundle with no fault flags, and SHALL zero all consecutive-divergence counters.
REQ-015 TMR, exactly one divergent: SHALL output the majority bundle and set that replica's fault flag; its consecutive counter and err_cnt SHALL increment, and the other replicas' consecutive counters SHALL zero.
REQ-016 TMR, divergent replica's consecutive count reaches THRESH: SHALL set its failed bit and go to DMR on the same edge that outputs this vote.
REQ-017 TMR, all three differ: SHALL output result=A and rd=rd_A with write_enable forced to 0, set all fault flags, increment all three err_cnt, and go to HALT.
REQ-018 DMR: SHALL vote only the two non-failed replicas; if they agree, it SHALL output their bundle with no fault flags, and the failed replica SHALL be ignored and raise no flag.
REQ-019 DMR, two survivors disagree: SHALL output result and rd of the lower-lettered survivor with write_enable=0, set both survivors' fault flags, increment their err_cnt, and go to HALT.
REQ-020 HALT: system_fault=1 sticky; out_valid SHALL still follow in_valid; result and rd SHALL be the A bundle; write_enable=0; the fault flags and err_cnt SHALL be unaffected.
REQ-021 err_cnt_x SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 clear_faults=1 SHALL, on that edge, set mode=TMR and clear failed, system_fault, err_cnt and the consecutive counters.
REQ-023 clear_faults=1 with in_valid=1 SHALL vote that cycle's bundle in TMR rules with its counters treated as zero, and the clear SHALL take priority over any resulting state change or increment.
REQ-024 The legal transitions SHALL be TMR->DMR, TMR->HALT, DMR->HALT, and any->TMR (only via clear_faults or rst); mode=3 SHALL be unreachable and, if entered, SHALL be treated as HALT.
REQ-025 In TMR, at most one replica SHALL be declarable failed per vote.

Reset
REQ-026 On rst=1 at a clock edge: out_valid=0, result=0, write_enable=0, rd=0, fault_A..C=0, failed=0, mode=0, system_fault=0, err_cnt=0, consecutive counters=0.
REQ-027 rst SHALL override clear_faults and in_valid, and a reset mid-HALT or mid-DMR SHALL return to TMR.

Verification (THRESH=3, CNT_W=8)
REQ-028 All equal, A=B=C=0x1234, we=1, rd=5 -> next cycle: out_valid=1, result=0x1234, write_enable=1, rd=5, no faults, mode=0.
REQ-029 B=0xDEAD with A=C=0x1, three consecutive valid cycles -> fault_B=1 each cycle; after the third edge, failed=3'b010, mode=1, err_cnt_B=3, result=0x1.
REQ-030 Same as REQ-029 but with an all-agree vote between the 2nd and 3rd divergence -> the consecutive count restarts, and failed stays 0 until 3 further divergences.
REQ-031 In DMR (B failed), A=0x5 and C=0x6 -> result=0x5, write_enable=0, fault_A=fault_C=1, mode=2, system_fault=1; later votes keep write_enable=0.
REQ-032 A=1, B=2, C=3 in TMR -> mode=2, all fault flags=1, write_enable=0; then clear_faults=1 -> mode=0, failed=0, err_cnt=0, system_fault=0.
REQ-033 300 single-replica-A divergences with THRESH=255 -> err_cnt_A saturates at 255.
